// File: rtl/ysyx_22041211_lsu_pkg.sv
// ysyx_22041211_lsu_pkg: load/store type and LSU state encodings shared by the LSU files
package ysyx_22041211_lsu_pkg;
  typedef enum logic [2:0] {LOAD_NONE, LB, LH, LW, LBU, LHU} load_e;
  typedef enum logic [1:0] {STORE_NONE, SB, SH, SW} store_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
  function automatic logic misaligned(input load_e ld, input store_e st, input logic [1:0] off);
    return ((st == SH || ld == LH || ld == LHU) && off[0]) || ((st == SW || ld == LW) && off != 2'b00);
  endfunction
endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// ysyx_22041211_lsu_align: store lane strobe/data replication and load byte/half extract with extension
module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_pkg::*;
(
  input  store_e      i_store,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_rs2,
  input  load_e       i_load,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  always_comb begin
    w_b     = 8'(i_rdata >> {i_ld_off, 3'b000});
    w_h     = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_strb  = i_store == SB ? 4'b0001 << i_st_off :
              i_store == SH ? 4'b0011 << i_st_off :
              i_store == SW ? 4'b1111 : 4'b0000;
    o_wdata = i_store == SB ? {4{i_rs2[7:0]}} :
              i_store == SH ? {2{i_rs2[15:0]}} : i_rs2;
    o_ldata = i_load == LB  ? {{24{w_b[7]}}, w_b} :
              i_load == LH  ? {{16{w_h[15]}}, w_h} :
              i_load == LW  ? i_rdata :
              i_load == LBU ? {24'b0, w_b} :
              i_load == LHU ? {16'b0, w_h} : 32'b0;
  end
endmodule

// File: rtl/ysyx_22041211_lsu.sv
// ysyx_22041211_lsu: memory stage FSM (IDLE/REQ/WAIT/DONE) over a single-outstanding data bus.
// YSYX_22041211_LSU_MISALIGN_EN adds misalign_o and traps misaligned half/word accesses without a bus request.
module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid_i,
  output logic                ex_ready_o,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  output logic                dmem_req_valid_o,
  input  logic                dmem_req_ready_i,
  output logic [ADDR_LEN-1:0] dmem_addr_o,
  output logic                dmem_wen_o,
  output logic [3:0]          dmem_wstrb_o,
  output logic [DATA_LEN-1:0] dmem_wdata_o,
  input  logic                dmem_resp_valid_i,
  input  logic [DATA_LEN-1:0] dmem_rdata_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic                wb_wd_o,
  output logic [4:0]          wb_wreg_o,
  output logic [DATA_LEN-1:0] wb_data_o
`ifdef YSYX_22041211_LSU_MISALIGN_EN
  ,
  output logic                misalign_o
`endif
);
  lsu_state_e          r_state;
  logic                r_ex_ready, r_req_valid, r_wen, r_wd, r_wb_valid, r_wb_wd;
  logic [ADDR_LEN-1:0] r_addr;
  logic [3:0]          r_strb;
  logic [DATA_LEN-1:0] r_wdata, r_wb_data;
  logic [4:0]          r_wreg, r_wb_wreg;
  logic [1:0]          r_off;
  load_e               r_ld;
  store_e              w_st;
  load_e               w_ld;
  logic                w_mem, w_acc, w_mis;
  logic [3:0]          w_strb;
  logic [DATA_LEN-1:0] w_wdata, w_ldata;
  // store wins when both types are set, so the load side is masked here
  assign w_st  = store_e'(store_type_i);
  assign w_ld  = w_st != STORE_NONE ? LOAD_NONE : load_e'(load_type_i);
  assign w_mem = w_st != STORE_NONE || w_ld != LOAD_NONE;
  assign w_acc = r_state == IDLE && r_ex_ready && ex_valid_i;
`ifdef YSYX_22041211_LSU_MISALIGN_EN
  logic r_mis;
  assign w_mis      = misaligned(w_ld, w_st, alu_result_i[1:0]);
  assign misalign_o = r_mis;
`else
  assign w_mis = 1'b0;
`endif
  ysyx_22041211_lsu_align u_align (
    .i_store (w_st),
    .i_st_off(alu_result_i[1:0]),
    .i_rs2   (mem_wdata_i),
    .i_load  (r_ld),
    .i_ld_off(r_off),
    .i_rdata (dmem_rdata_i),
    .o_strb  (w_strb),
    .o_wdata (w_wdata),
    .o_ldata (w_ldata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ex_ready  <= 1'b0;
      r_req_valid <= 1'b0;
      r_addr      <= '0;
      r_wen       <= 1'b0;
      r_strb      <= 4'b0;
      r_wdata     <= '0;
      r_ld        <= LOAD_NONE;
      r_off       <= 2'b0;
      r_wd        <= 1'b0;
      r_wreg      <= 5'b0;
      r_wb_valid  <= 1'b0;
      r_wb_wd     <= 1'b0;
      r_wb_wreg   <= 5'b0;
      r_wb_data   <= '0;
`ifdef YSYX_22041211_LSU_MISALIGN_EN
      r_mis       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_ex_ready <= ~w_acc;
          if (w_acc) begin
            r_ld    <= w_ld;
            r_off   <= alu_result_i[1:0];
            r_wd    <= wd_i & (w_st == STORE_NONE);
            r_wreg  <= wreg_i;
            r_addr  <= {alu_result_i[ADDR_LEN-1:2], 2'b00};
            r_wen   <= w_st != STORE_NONE;
            r_strb  <= w_strb;
            r_wdata <= w_wdata;
            if (w_mem && !w_mis) begin
              r_state     <= REQ;
              r_req_valid <= 1'b1;
            end else begin
              r_state    <= DONE;
              r_wb_valid <= 1'b1;
              r_wb_data  <= alu_result_i;
              r_wb_wd    <= wd_i & ~w_mis;
              r_wb_wreg  <= wreg_i;
`ifdef YSYX_22041211_LSU_MISALIGN_EN
              r_mis      <= w_mis;
`endif
            end
          end
        end
        REQ: if (dmem_req_ready_i) begin
          r_req_valid <= 1'b0;
          r_state     <= WAIT;
        end
        WAIT: if (dmem_resp_valid_i) begin
          r_state    <= DONE;
          r_wb_valid <= 1'b1;
          r_wb_data  <= w_ldata;
          r_wb_wd    <= r_wd;
          r_wb_wreg  <= r_wreg;
        end
        DONE: if (wb_ready_i) begin
          r_state    <= IDLE;
          r_wb_valid <= 1'b0;
          r_ex_ready <= 1'b1;
`ifdef YSYX_22041211_LSU_MISALIGN_EN
          r_mis      <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign ex_ready_o       = r_ex_ready;
  assign dmem_req_valid_o = r_req_valid;
  assign dmem_addr_o      = r_addr;
  assign dmem_wen_o       = r_wen;
  assign dmem_wstrb_o     = r_strb;
  assign dmem_wdata_o     = r_wdata;
  assign wb_valid_o       = r_wb_valid;
  assign wb_wd_o          = r_wb_wd;
  assign wb_wreg_o        = r_wb_wreg;
  assign wb_data_o        = r_wb_data;
endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// tb_ysyx_22041211_lsu: directed scoreboard bench for the LSU; define YSYX_22041211_LSU_MISALIGN_EN to cover the trap path
module tb_ysyx_22041211_lsu;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ex_valid_i = 1'b0, wd_i = 1'b0, dmem_req_ready_i = 1'b0, dmem_resp_valid_i = 1'b0, wb_ready_i = 1'b0;
  logic [31:0] alu_result_i = '0, mem_wdata_i = '0, dmem_rdata_i = '0;
  logic [2:0]  load_type_i = '0;
  logic [1:0]  store_type_i = '0;
  logic [4:0]  wreg_i = '0;
  logic        ex_ready_o, dmem_req_valid_o, dmem_wen_o, wb_valid_o, wb_wd_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, wb_data_o;
  logic [3:0]  dmem_wstrb_o;
  logic [4:0]  wb_wreg_o;
`ifdef YSYX_22041211_LSU_MISALIGN_EN
  logic        misalign_o;
`endif
  typedef struct {logic [31:0] data; logic wd; logic [4:0] wreg; logic chk_data;} wb_t;
  wb_t sb_q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ysyx_22041211_lsu dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .alu_result_i(alu_result_i), .mem_wdata_i(mem_wdata_i), .load_type_i(load_type_i),
    .store_type_i(store_type_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_addr_o(dmem_addr_o), .dmem_wen_o(dmem_wen_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_resp_valid_i(dmem_resp_valid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o),
    .wb_data_o(wb_data_o)
`ifdef YSYX_22041211_LSU_MISALIGN_EN
    , .misalign_o(misalign_o)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [1:0] off, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[8*off +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (lt)
      3'd1: return {{24{b[7]}}, b};
      3'd2: return {{16{h[15]}}, h};
      3'd3: return rd;
      3'd4: return {24'b0, b};
      3'd5: return {16'b0, h};
      default: return 32'b0;
    endcase
  endfunction
  function automatic logic [3:0] m_strb(input logic [1:0] st, input logic [1:0] off);
    case (st)
      2'd1: return 4'b0001 << off;
      2'd2: return 4'b0011 << off;
      2'd3: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction
  function automatic logic [31:0] m_wdata(input logic [1:0] st, input logic [31:0] rs2);
    case (st)
      2'd1: return {4{rs2[7:0]}};
      2'd2: return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction
  task automatic issue(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] lt, input logic [1:0] st, input logic wd, input logic [4:0] wreg);
    int n = 0;
    while (!ex_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ex_ready_before_issue", ex_ready_o, 1);
    ex_valid_i = 1'b1; alu_result_i = alu; mem_wdata_i = rs2; load_type_i = lt; store_type_i = st; wd_i = wd; wreg_i = wreg;
    @(negedge clk);
    ex_valid_i = 1'b0; alu_result_i = $urandom; mem_wdata_i = $urandom; load_type_i = 3'd0; store_type_i = 2'd0;
  endtask
  task automatic finish_wb(input int wb_lat);
    wb_t e;
    chk("sb_nonempty", sb_q.size() != 0, 1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      for (int i = 0; i <= wb_lat; i++) begin
        chk("wb_valid", wb_valid_o, 1);
        chk("ex_ready_in_done", ex_ready_o, 0);
        if (e.chk_data) chk("wb_data", wb_data_o, e.data);
        chk("wb_wd", wb_wd_o, e.wd);
        chk("wb_wreg", wb_wreg_o, e.wreg);
        wb_ready_i = (i == wb_lat);
        @(negedge clk);
      end
      wb_ready_i = 1'b0;
      chk("wb_valid_drop", wb_valid_o, 0);
      chk("ex_ready_after_wb", ex_ready_o, 1);
    end
  endtask
  task automatic run_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] lt, input logic [1:0] st,
                        input logic wd, input logic [4:0] wreg, input logic [31:0] rd, input int req_lat, input int resp_lat, input int wb_lat);
    wb_t e;
    e.wreg = wreg;
    e.wd = (st != 0) ? 1'b0 : wd;
    e.data = (lt != 0) ? m_load(lt, alu[1:0], rd) : alu;
    e.chk_data = (st == 0);
    sb_q.push_back(e);
    issue(alu, rs2, lt, st, wd, wreg);
    if (lt != 0 || st != 0) begin
      for (int i = 0; i <= req_lat; i++) begin
        chk("req_valid", dmem_req_valid_o, 1);
        chk("req_addr", dmem_addr_o, {alu[31:2], 2'b00});
        chk("req_wen", dmem_wen_o, st != 0);
        if (st != 0) begin
          chk("req_strb", dmem_wstrb_o, m_strb(st, alu[1:0]));
          chk("req_wdata", dmem_wdata_o, m_wdata(st, rs2));
        end
        dmem_req_ready_i = (i == req_lat);
        @(negedge clk);
      end
      dmem_req_ready_i = 1'b0;
      chk("req_drop", dmem_req_valid_o, 0);
      for (int i = 0; i < resp_lat; i++) begin
        chk("no_wb_in_wait", wb_valid_o, 0);
        @(negedge clk);
      end
      dmem_resp_valid_i = 1'b1; dmem_rdata_i = rd;
      @(negedge clk);
      dmem_resp_valid_i = 1'b0; dmem_rdata_i = $urandom;
    end else chk("alu_no_req", dmem_req_valid_o, 0);
    finish_wb(wb_lat);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ex_ready", ex_ready_o, 0);
    chk("rst_req_valid", dmem_req_valid_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ex_ready_after_release", ex_ready_o, 1);
    run_op(32'h0000_1234, 32'h0, 3'd0, 2'd0, 1'b1, 5'd5, 32'h0, 0, 0, 0);
    run_op(32'h8000_0003, 32'hAABB_CCDD, 3'd0, 2'd1, 1'b1, 5'd7, 32'h0, 0, 0, 0);
    run_op(32'h8000_0002, 32'h0, 3'd1, 2'd0, 1'b1, 5'd8, 32'h00F1_0000, 0, 0, 0);
    run_op(32'h8000_0002, 32'h0, 3'd4, 2'd0, 1'b1, 5'd9, 32'h00F1_0000, 0, 1, 0);
    run_op(32'h0000_0002, 32'h0, 3'd2, 2'd0, 1'b1, 5'd10, 32'h8001_FFFF, 3, 2, 0);
    run_op(32'hCAFE_0000, 32'h0, 3'd0, 2'd0, 1'b1, 5'd11, 32'h0, 0, 0, 4);
    run_op(32'h0000_0102, 32'h1234_ABCD, 3'd0, 2'd2, 1'b0, 5'd0, 32'h0, 1, 0, 1);
    run_op(32'h0000_0104, 32'h5566_7788, 3'd0, 2'd3, 1'b1, 5'd3, 32'h0, 0, 0, 0);
    run_op(32'h0000_0200, 32'h0, 3'd5, 2'd0, 1'b1, 5'd12, 32'h1234_F00D, 0, 0, 0);
    run_op(32'h0000_0203, 32'h0, 3'd1, 2'd0, 1'b1, 5'd13, 32'h7F00_0000, 0, 0, 0);
    run_op(32'h0000_0208, 32'h0, 3'd3, 2'd0, 1'b1, 5'd14, 32'hDEAD_BEEF, 2, 3, 2);
    run_op(32'h0000_0301, 32'hFFFF_FF5A, 3'd3, 2'd1, 1'b1, 5'd15, 32'h0, 0, 0, 0);
    run_op(32'h0000_0ABC, 32'h0, 3'd0, 2'd0, 1'b1, 5'd0, 32'h0, 0, 0, 0);
`ifdef YSYX_22041211_LSU_MISALIGN_EN
    issue(32'h0000_0006, 32'h0, 3'd3, 2'd0, 1'b1, 5'd4);
    chk("mis_no_req", dmem_req_valid_o, 0);
    chk("mis_wb_valid", wb_valid_o, 1);
    chk("mis_flag", misalign_o, 1);
    chk("mis_wb_wd", wb_wd_o, 0);
    wb_ready_i = 1'b1;
    @(negedge clk);
    wb_ready_i = 1'b0;
    chk("mis_flag_clear", misalign_o, 0);
    run_op(32'h0000_0010, 32'h0, 3'd3, 2'd0, 1'b1, 5'd6, 32'h0BAD_F00D, 0, 0, 0);
`else
    run_op(32'h0000_0403, 32'h0000_BEEF, 3'd0, 2'd2, 1'b0, 5'd0, 32'h0, 0, 0, 0);
`endif
    issue(32'h0000_0010, 32'h0, 3'd3, 2'd0, 1'b1, 5'd6);
    chk("rstwait_req_valid", dmem_req_valid_o, 1);
    dmem_req_ready_i = 1'b1;
    @(negedge clk);
    dmem_req_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ex_ready", ex_ready_o, 0);
    chk("midrst_req_valid", dmem_req_valid_o, 0);
    chk("midrst_addr", dmem_addr_o, 0);
    chk("midrst_wen", dmem_wen_o, 0);
    chk("midrst_strb", dmem_wstrb_o, 0);
    chk("midrst_wdata", dmem_wdata_o, 0);
    chk("midrst_wb_valid", wb_valid_o, 0);
    chk("midrst_wb_wd", wb_wd_o, 0);
    chk("midrst_wb_wreg", wb_wreg_o, 0);
    chk("midrst_wb_data", wb_data_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ex_ready", ex_ready_o, 1);
    run_op(32'h8000_0001, 32'h0, 3'd1, 2'd0, 1'b1, 5'd20, 32'h0000_8000, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
